// File: rtl/xbar_arb_pkg.sv
// Shared types for the crossbar output LRU arbiter.
package xbar_arb_pkg;

    // ARB_IDLE: no owner, looking for a requester.
    // ARB_LOCKED: one requester owns the output until its packet ends.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xbar_arb_pick.sv
// Combinational pick: walks the priority list from entry 0 and reports the
// first list position whose requester id has req_valid set.
module xbar_arb_pick #(
    parameter int CANDIDATE = 4,
    parameter int IDW       = $clog2(CANDIDATE)
) (
    input  logic [CANDIDATE-1:0][IDW-1:0] i_list,
    input  logic [CANDIDATE-1:0]          i_req,
    output logic                          o_found,
    output logic [IDW-1:0]                o_pos,
    output logic [IDW-1:0]                o_id
);

    // Scan from the tail down so the lowest requesting position wins last.
    always_comb begin
        o_found = 1'b0;
        o_pos   = '0;
        o_id    = '0;
        for (int p = CANDIDATE - 1; p >= 0; p--) begin
            if (i_req[i_list[p]]) begin
                o_found = 1'b1;
                o_pos   = p[IDW-1:0];
                o_id    = i_list[p];
            end
        end
    end

endmodule

// File: rtl/xbar_lru_arbiter.sv
// Packet-locked LRU arbiter for one crossbar output.
// An owner keeps the output until a beat with req_last fires; the finishing
// owner then moves to the tail of the priority list (least recently used).
// Optional feature: define ARB_TIMEOUT_EN to build the stall watchdog that
// force-releases an owner after TIMEOUT_CYCLES non-firing locked cycles.
// Handshake: a beat transfers when req_valid[grant_id] & dst_ready are both
// high on a rising clk edge while grant_valid=1; nothing else moves a beat.
module xbar_lru_arbiter
    import xbar_arb_pkg::*;
#(
    parameter int CANDIDATE      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CANDIDATE-1:0]         req_valid,
    input  logic [CANDIDATE-1:0]         req_last,
    input  logic                         dst_ready,
    output logic                         grant_valid,
    output logic [CANDIDATE-1:0]         grant_vec,
    output logic [$clog2(CANDIDATE)-1:0] grant_id,
    output logic                         timeout_err,
    output arb_state_e                   dbg_state
);

    localparam int IDW = $clog2(CANDIDATE);

    // Reject configurations the list/pick logic cannot represent.
    if (CANDIDATE < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("xbar_lru_arbiter: CANDIDATE must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e                   r_state;
    logic [CANDIDATE-1:0][IDW-1:0] r_list;
    logic                         r_grant_valid;
    logic [CANDIDATE-1:0]         r_grant_vec;
    logic [IDW-1:0]               r_grant_id;
    logic [IDW-1:0]               r_owner_pos;
    logic                         r_timeout_err;

    arb_state_e                   w_state_nxt;
    logic [CANDIDATE-1:0][IDW-1:0] w_list_nxt;
    logic                         w_grant_valid_nxt;
    logic [CANDIDATE-1:0]         w_grant_vec_nxt;
    logic [IDW-1:0]               w_grant_id_nxt;
    logic [IDW-1:0]               w_owner_pos_nxt;
    logic                         w_timeout_err_nxt;

    logic                         w_found;
    logic [IDW-1:0]               w_pick_pos;
    logic [IDW-1:0]               w_pick_id;
    logic                         w_fire;
    logic                         w_end;
    logic                         w_timeout;

    xbar_arb_pick #(
        .CANDIDATE (CANDIDATE),
        .IDW       (IDW)
    ) u_pick (
        .i_list  (r_list),
        .i_req   (req_valid),
        .o_found (w_found),
        .o_pos   (w_pick_pos),
        .o_id    (w_pick_id)
    );

    assign w_fire = (r_state == ARB_LOCKED) && req_valid[r_grant_id] && dst_ready;
    assign w_end  = w_fire && req_last[r_grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] r_stall;

    // The stall that would reach the limit this cycle triggers the release.
    assign w_timeout = (r_state == ARB_LOCKED) && !w_fire &&
                       (r_stall == SW'(TIMEOUT_CYCLES - 1));

    // Stall counter: runs only on non-firing locked cycles, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (r_state != ARB_LOCKED || w_fire || w_timeout) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + SW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic; the owner's position shifts to tail on release.
    always_comb begin
        w_state_nxt       = r_state;
        w_list_nxt        = r_list;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_vec_nxt   = r_grant_vec;
        w_grant_id_nxt    = r_grant_id;
        w_owner_pos_nxt   = r_owner_pos;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt                = ARB_LOCKED;
                    w_grant_valid_nxt          = 1'b1;
                    w_grant_vec_nxt            = '0;
                    w_grant_vec_nxt[w_pick_id] = 1'b1;
                    w_grant_id_nxt             = w_pick_id;
                    w_owner_pos_nxt            = w_pick_pos;
                end
            end
            ARB_LOCKED: begin
                if (w_end || w_timeout) begin
                    w_state_nxt       = ARB_IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_grant_vec_nxt   = '0;
                    w_grant_id_nxt    = '0;
                    w_owner_pos_nxt   = '0;
                    w_timeout_err_nxt = w_timeout;
                    for (int i = 0; i < CANDIDATE - 1; i++) begin
                        if (i >= int'(r_owner_pos)) begin
                            w_list_nxt[i] = r_list[i+1];
                        end
                    end
                    w_list_nxt[CANDIDATE-1] = r_grant_id;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset restores the identity priority list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_vec   <= '0;
            r_grant_id    <= '0;
            r_owner_pos   <= '0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < CANDIDATE; i++) begin
                r_list[i] <= i[IDW-1:0];
            end
        end else begin
            r_state       <= w_state_nxt;
            r_list        <= w_list_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_vec   <= w_grant_vec_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_owner_pos   <= w_owner_pos_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_vec   = r_grant_vec;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule
